// File: rtl/serv_rf_serdes.sv
// serv_rf_serdes: bit-serial <-> word-parallel adapter between the SERV core's
// serial register-file ports and a width-wide register RAM (1-cycle read latency).
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_rreq                read request pulse (sampled while idle)
//   i_rreg0 / i_rreg1     rs1 / rs2 index, stable for the whole read
//   o_ready               one-cycle pulse, serial read data follows next cycle
//   o_rdata0 / o_rdata1   rs1 / rs2 serial bits, LSB first
//   i_wen, i_wreg, i_wdata  serial rd write bit, rd index, rd bit
//   o_waddr, o_wdata, o_wen RAM write port
//   o_raddr, o_ren        RAM read port
//   i_rdata               RAM read data, valid one cycle after o_ren
module serv_rf_serdes #(
    parameter int unsigned width    = 8,
    parameter int unsigned csr_regs = 4,
    parameter int unsigned depth    = 32*(32+csr_regs)/width,
    parameter int unsigned aw       = $clog2(depth),
    parameter int unsigned rw       = aw-(5-$clog2(width))
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rreq,
    input  logic [rw-1:0]    i_rreg0,
    input  logic [rw-1:0]    i_rreg1,
    output logic             o_ready,
    output logic             o_rdata0,
    output logic             o_rdata1,
    input  logic             i_wen,
    input  logic [rw-1:0]    i_wreg,
    input  logic             i_wdata,
    output logic [aw-1:0]    o_waddr,
    output logic [width-1:0] o_wdata,
    output logic             o_wen,
    output logic [aw-1:0]    o_raddr,
    output logic             o_ren,
    input  logic [width-1:0] i_rdata
);

    localparam int unsigned LW       = $clog2(width);
    localparam int unsigned SW       = 5 - LW;
    localparam logic [4:0]  OFF_MASK = 5'(width - 1);
    localparam logic [4:0]  OFF_LAST = 5'(width - 1);
    localparam logic [4:0]  LAST_WORD = 5'(32/width - 1);

    typedef enum logic [2:0] {IDLE, PRE0, PRE1, PRE2, STREAM} state_t;

    // RAM address of word w of register r
    function automatic logic [aw-1:0] ram_addr(input logic [rw-1:0] r, input logic [4:0] w);
        return (aw'(r) << SW) | aw'(w);
    endfunction

    state_t            state_q, state_d;
    logic [4:0]        rcnt_q, rcnt_d;
    logic [width-1:0]  shift0_q, shift0_d, shift1_q, shift1_d;
    logic [width-1:0]  hold0_q, hold0_d, hold1_q, hold1_d;
    logic              ready_q, ready_d;
    logic              ren_q, ren_d;
    logic [aw-1:0]     raddr_q, raddr_d;
    logic              rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic [4:0]        word_q, off_q, word_d, off_d;

    logic [4:0]        wcnt_q, wcnt_d;
    logic [width-1:0]  acc_q, acc_d;
    logic              wen_q, wen_d;
    logic [aw-1:0]     waddr_q, waddr_d;
    logic [width-1:0]  wdata_q, wdata_d;

    assign word_q = rcnt_q >> LW;
    assign off_q  = rcnt_q & OFF_MASK;
    assign word_d = rcnt_d >> LW;
    assign off_d  = rcnt_d & OFF_MASK;

    // Read FSM state register and read-side datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            rcnt_q   <= '0;
            shift0_q <= '0;
            shift1_q <= '0;
            hold0_q  <= '0;
            hold1_q  <= '0;
            ready_q  <= 1'b0;
            ren_q    <= 1'b0;
            raddr_q  <= '0;
            rdata0_q <= 1'b0;
            rdata1_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            shift0_q <= shift0_d;
            shift1_q <= shift1_d;
            hold0_q  <= hold0_d;
            hold1_q  <= hold1_d;
            ready_q  <= ready_d;
            ren_q    <= ren_d;
            raddr_q  <= raddr_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Read FSM next state and shift/hold datapath
    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        shift0_d = shift0_q;
        shift1_d = shift1_q;
        hold0_d  = hold0_q;
        hold1_d  = hold1_q;
        unique case (state_q)
            IDLE: begin
                if (i_rreq) state_d = PRE0;
            end
            PRE0: begin
                state_d = PRE1;
            end
            PRE1: begin
                state_d  = PRE2;
                shift0_d = i_rdata;
            end
            PRE2: begin
                state_d  = STREAM;
                shift1_d = i_rdata;
                rcnt_d   = '0;
            end
            STREAM: begin
                rcnt_d = rcnt_q + 5'd1;
                if (off_q == OFF_LAST) begin
                    shift0_d = hold0_q;
                    shift1_d = hold1_q;
                end else begin
                    shift0_d = {1'b0, shift0_q[width-1:1]};
                    shift1_d = {1'b0, shift1_q[width-1:1]};
                end
                // Prefetched words arrive one cycle after their o_ren slots
                if (word_q != LAST_WORD && off_q == 5'd1) hold0_d = i_rdata;
                if (word_q != LAST_WORD && off_q == 5'd2) hold1_d = i_rdata;
                if (rcnt_q == 5'd31) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read-side outputs, decoded from the next state so they leave registers
    always_comb begin
        ready_d  = (state_d == PRE2);
        ren_d    = 1'b0;
        raddr_d  = raddr_q;
        rdata0_d = (state_d == STREAM) ? shift0_d[0] : 1'b0;
        rdata1_d = (state_d == STREAM) ? shift1_d[0] : 1'b0;
        unique case (state_d)
            PRE0: begin
                ren_d   = 1'b1;
                raddr_d = ram_addr(i_rreg0, 5'd0);
            end
            PRE1: begin
                ren_d   = 1'b1;
                raddr_d = ram_addr(i_rreg1, 5'd0);
            end
            STREAM: begin
                if (word_d != LAST_WORD && off_d == 5'd0) begin
                    ren_d   = 1'b1;
                    raddr_d = ram_addr(i_rreg0, 5'(word_d + 5'd1));
                end else if (word_d != LAST_WORD && off_d == 5'd1) begin
                    ren_d   = 1'b1;
                    raddr_d = ram_addr(i_rreg1, 5'(word_d + 5'd1));
                end
            end
            default: begin
                ren_d = 1'b0;
            end
        endcase
    end

    // Write-side registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wcnt_q  <= '0;
            acc_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wcnt_q  <= wcnt_d;
            acc_q   <= acc_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Serial-to-word assembly; x0 writes are assembled but never committed
    always_comb begin
        wcnt_d  = wcnt_q;
        acc_d   = acc_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (i_wen) begin
            wcnt_d = wcnt_q + 5'd1;
            acc_d  = {i_wdata, acc_q[width-1:1]};
            if ((wcnt_q & OFF_MASK) == OFF_LAST) begin
                wen_d   = (i_wreg != '0);
                wdata_d = acc_d;
                waddr_d = ram_addr(i_wreg, wcnt_q >> LW);
            end
        end
    end

    assign o_ready  = ready_q;
    assign o_rdata0 = rdata0_q;
    assign o_rdata1 = rdata1_q;
    assign o_ren    = ren_q;
    assign o_raddr  = raddr_q;
    assign o_wen    = wen_q;
    assign o_waddr  = waddr_q;
    assign o_wdata  = wdata_q;

endmodule

// File: tb/tb_serv_rf_serdes.sv
// Bench for serv_rf_serdes: three instances (width 4, 8, 32) share one stimulus
// stream; each has its own RAM model, expectation queues and output monitor.
module tb_serv_rf_serdes;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] d0;
        logic [31:0] d1;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rreq = 1'b0;
    logic [5:0]  rreg0 = '0;
    logic [5:0]  rreg1 = '0;
    logic        wen = 1'b0;
    logic [5:0]  wreg = '0;
    logic        wdata = 1'b0;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [31:0] gold [36];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input int r);
        if (r == 0) return 32'h0;
        if (r == 5) return 32'hDEADBEEF;
        if (r == 6) return 32'h12345678;
        return 32'(r) * 32'h9E3779B1 + 32'h0F1E2D3C;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned W   = (g == 0) ? 4 : (g == 1) ? 8 : 32;
        localparam int unsigned DEP = 32*36/W;
        localparam int unsigned AW  = $clog2(DEP);
        localparam int unsigned SW  = 5 - $clog2(W);
        localparam int unsigned NW  = 32/W;

        logic          rdy, rd0, rd1, wen_o, ren;
        logic [AW-1:0] waddr, raddr;
        logic [W-1:0]  wdat;
        logic [W-1:0]  rdat = '0;
        logic [W-1:0]  mem [DEP];

        serv_rf_serdes #(.width(W), .csr_regs(4)) dut (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_rreq   (rreq),
            .i_rreg0  (rreg0),
            .i_rreg1  (rreg1),
            .o_ready  (rdy),
            .o_rdata0 (rd0),
            .o_rdata1 (rd1),
            .i_wen    (wen),
            .i_wreg   (wreg),
            .i_wdata  (wdata),
            .o_waddr  (waddr),
            .o_wdata  (wdat),
            .o_wen    (wen_o),
            .o_raddr  (raddr),
            .o_ren    (ren),
            .i_rdata  (rdat)
        );

        // RAM: 1-cycle read latency, x0 reads as zero, read-old-data
        initial begin
            for (int r = 0; r < 36; r++)
                for (int k = 0; k < int'(NW); k++)
                    mem[r*NW + k] = W'(init_val(r) >> (k*W));
        end
        always @(posedge clk) begin
            if (ren) rdat <= ((raddr >> SW) == '0) ? '0 : mem[raddr];
            if (wen_o) mem[waddr] <= wdat;
        end

        // Expectation model: watches stimulus, pushes expected responses
        rd_exp_t         rq[$];
        logic [AW-1:0]   aq[$];
        logic [AW+W-1:0] wq[$];
        int unsigned     busy = 0;
        logic [4:0]      mwcnt = '0;
        logic [31:0]     mval = '0;
        logic            rst_seen = 1'b1;

        always @(posedge clk) begin
            rst_seen = rst;
            if (rst) begin
                busy  = 0;
                mwcnt = '0;
                rq.delete();
                aq.delete();
                wq.delete();
            end else begin
                if (busy != 0) begin
                    busy--;
                end else if (rreq) begin
                    busy = 35;
                    rq.push_back({32'(cyc + 3), gold[rreg0], gold[rreg1]});
                    for (int j = 0; j < int'(NW); j++) begin
                        aq.push_back(AW'((int'(rreg0) << SW) + j));
                        aq.push_back(AW'((int'(rreg1) << SW) + j));
                    end
                end
                if (wen) begin
                    int unsigned b;
                    b = mwcnt;
                    mval[mwcnt] = wdata;
                    if ((b % W) == W - 1 && wreg != 0)
                        wq.push_back({AW'((int'(wreg) << SW) + b / W), W'(mval >> (b - (W - 1)))});
                    mwcnt = mwcnt + 5'd1;
                end
            end
        end

        // Monitor: pops and compares whenever the DUT presents an output
        int          scnt = 0;
        int          pending = 0;
        logic [31:0] e0 = '0, e1 = '0;
        rd_exp_t     re;

        always @(negedge clk) begin
            if (rst_seen) begin
                scnt = 0;
                chk($sformatf("w%0d_reset_outputs", W), 64'({rdy, ren, wen_o, rd0, rd1}), 64'd0);
            end else begin
                if (ren) begin
                    if (aq.size() == 0) chk($sformatf("w%0d_unexpected_ren", W), 64'(raddr), 64'hFFFF);
                    else chk($sformatf("w%0d_raddr", W), 64'(raddr), 64'(aq.pop_front()));
                end
                if (wen_o) begin
                    if (wq.size() == 0) chk($sformatf("w%0d_unexpected_wen", W), 64'({waddr, wdat}), 64'hFFFF);
                    else chk($sformatf("w%0d_write", W), 64'({waddr, wdat}), 64'(wq.pop_front()));
                end
                if (scnt != 0) begin
                    chk($sformatf("w%0d_rdata0_bit%0d", W, 32 - scnt), 64'(rd0), 64'(e0[32 - scnt]));
                    chk($sformatf("w%0d_rdata1_bit%0d", W, 32 - scnt), 64'(rd1), 64'(e1[32 - scnt]));
                    scnt--;
                end
                if (rdy) begin
                    if (rq.size() == 0) begin
                        chk($sformatf("w%0d_unexpected_ready", W), 64'(cyc), 64'hFFFF_FFFF_FFFF);
                    end else begin
                        re = rq.pop_front();
                        chk($sformatf("w%0d_ready_cycle", W), 64'(cyc), 64'(re.cyc));
                        e0 = re.d0;
                        e1 = re.d1;
                        scnt = 32;
                    end
                end
            end
            pending = rq.size() + aq.size() + wq.size() + scnt;
        end
    end

    task automatic do_read(input logic [5:0] r0, input logic [5:0] r1,
                           input int reask_k, input int rst_k);
        @(posedge clk); #1;
        rreg0 = r0;
        rreg1 = r1;
        rreq  = 1'b1;
        for (int k = 1; k <= 38; k++) begin
            @(posedge clk); #1;
            rreq = (k == reask_k);
            if (rst_k != 0 && k == rst_k) rst = 1'b1;
            if (rst_k != 0 && k == rst_k + 2) rst = 1'b0;
        end
    endtask

    task automatic do_write(input logic [5:0] r, input logic [31:0] v, input int gap_after);
        @(posedge clk); #1;
        wreg = r;
        for (int i = 0; i < 32; i++) begin
            wen   = 1'b1;
            wdata = v[i];
            @(posedge clk); #1;
            if (i == gap_after) begin
                wen   = 1'b0;
                wdata = 1'b1;
                repeat (3) begin @(posedge clk); #1; end
            end
        end
        wen   = 1'b0;
        wdata = 1'b0;
        if (r != 0) gold[r] = v;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < 36; r++) gold[r] = init_val(r);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        do_read(6'd5, 6'd6, 0, 0);
        do_write(6'd7, 32'hA5A5F00F, -1);
        do_write(6'd0, 32'hA5A5F00F, -1);
        do_write(6'd8, 32'hA5A5F00F, 10);
        do_read(6'd7, 6'd8, 0, 0);
        do_read(6'd0, 6'd33, 0, 0);
        fork
            do_read(6'd35, 6'd7, 0, 0);
            do_write(6'd9, 32'h01234567, 20);
        join
        do_read(6'd9, 6'd0, 0, 0);
        do_read(6'd6, 6'd5, 8, 16);
        do_read(6'd5, 6'd6, 0, 0);

        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        chk("w4_pending_at_end", 64'(g_inst[0].pending), 64'd0);
        chk("w8_pending_at_end", 64'(g_inst[1].pending), 64'd0);
        chk("w32_pending_at_end", 64'(g_inst[2].pending), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
